// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the CPU decoder.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    // Codes 0-3 are the iterative operations; 4-7 never enter the datapath.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitude capture, shift-add multiply and restoring divide steps,
// plus the sign fix-up that produces the HI/LO results.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [2:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] res_hi_o,
    output logic [Width-1:0] res_lo_o
);

    logic [2*Width-1:0] acc_q, acc_d;
    logic [Width-1:0]   rem_q, rem_d;
    logic [Width-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;

    logic               a_neg, b_neg;
    logic [Width-1:0]   a_mag, b_mag;
    logic [Width:0]     mul_sum;
    logic [Width:0]     div_shift;
    logic [Width-1:0]   div_diff;
    logic               div_ge;
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   quo, rem;

    always_comb begin
        a_neg = op_is_signed(op_i) && a_i[Width-1];
        b_neg = op_is_signed(op_i) && b_i[Width-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;

        // Multiply: accumulate into the upper half, shift the multiplier out the bottom.
        mul_sum = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: quotient bits shift into acc_q[Width-1:0] as dividend bits shift out.
        div_shift = {rem_q, acc_q[Width-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[Width-1:0] - opnd_q;
    end

    always_comb begin
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        if (load_i) begin
            is_div_d = op_is_div(op_i);
            rem_d    = '0;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            if (!op_is_div(op_i)) begin
                acc_d    = {{Width{1'b0}}, b_mag};
                opnd_d   = a_mag;
                neg_hi_d = 1'b0;
            end else if (b_i == '0) begin
                // Preload the fixed divide-by-zero result so FIXUP needs no special case.
                acc_d    = {{Width{1'b0}}, {Width{1'b1}}};
                rem_d    = a_i;
                opnd_d   = '0;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
            end else begin
                acc_d  = {{Width{1'b0}}, a_mag};
                opnd_d = b_mag;
            end
        end else if (step_i) begin
            if (is_div_q) begin
                rem_d              = div_ge ? div_diff : div_shift[Width-1:0];
                acc_d[Width-1:0]   = {acc_q[Width-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[Width-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    always_comb begin
        prod     = neg_lo_q ? -acc_q : acc_q;
        quo      = neg_lo_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
        rem      = neg_hi_q ? -rem_q : rem_q;
        res_hi_o = is_div_q ? rem : prod[2*Width-1:Width];
        res_lo_o = is_div_q ? quo : prod[Width-1:0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Controller for the iterative mul/div unit: owns HI/LO, the step counter and
// the stall/done handshake with the CPU pipeline.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    md_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             accept_md;
    logic             dp_load, dp_step;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign accept_md = clk_enable && (state_q == IDLE) && start && op_is_muldiv(op);
    assign dp_load   = accept_md;
    assign dp_step   = clk_enable && (state_q == CALC);

    muldiv_datapath #(
        .Width (WIDTH)
    ) u_datapath (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .op_i     (op),
        .a_i      (op_a),
        .b_i      (op_b),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == MD_MTHI) begin
                            hi_q <= op_a;
                        end else if (op == MD_MTLO) begin
                            lo_q <= op_a;
                        end else if (op_is_muldiv(op)) begin
                            cnt_q   <= '0;
                            state_q <= (op_is_div(op) && (op_b == '0)) ? FIXUP : CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy && (start || hilo_read);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
